// File: rtl/g2_term_detector.sv
// Product-term detector with a two-term ordered sequencer.
// Each term compares the masked input against a programmed value and counts
// consecutive matching valid samples. A term is qualified (y low) while its
// count sits at HOLD. The sequencer looks for term 0 qualifying and then
// term 1 qualifying within WINDOW cycles, pulses seq_hit, and counts hits.
//
//   state | meaning
//   IDLE  | waiting for term 0 to qualify
//   ARMED | term 0 seen, timer running, waiting for term 1
//   HIT   | sequence detected, seq_hit high for this cycle
module g2_term_detector #(
  parameter int WIDTH  = 4,
  parameter int TERMS  = 2,
  parameter int HOLD   = 3,
  parameter int WINDOW = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] x,
  input  logic             in_valid,
  input  logic             cfg_we,
  input  logic [2:0]       cfg_idx,
  input  logic [WIDTH-1:0] cfg_mask,
  input  logic [WIDTH-1:0] cfg_val,
  input  logic             clr,
  output logic [TERMS-1:0] y,
  output logic             seq_hit,
  output logic [1:0]       state,
  output logic [7:0]       hit_count
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ARMED = 2'd1,
    S_HIT   = 2'd2
  } state_t;

  localparam logic [3:0] HOLD_C   = 4'(HOLD);
  localparam logic [7:0] WIN_LAST = 8'(WINDOW - 1);

  logic [WIDTH-1:0] mask_q [TERMS];
  logic [WIDTH-1:0] val_q  [TERMS];
  logic [3:0]       cnt_q  [TERMS];
  logic [TERMS-1:0] match;
  logic [TERMS-1:0] qual;
  logic [1:0]       qual_prev_q;
  logic [1:0]       rise;
  state_t           state_q, state_d;
  logic [7:0]       timer_q, timer_d;

  // Per-term match against the current sample and qualification from the count.
  always_comb begin
    match = '0;
    qual  = '0;
    for (int i = 0; i < TERMS; i++) begin
      match[i] = (mask_q[i] != '0) && ((x & mask_q[i]) == (val_q[i] & mask_q[i]));
      qual[i]  = (cnt_q[i] == HOLD_C);
    end
  end

  // Only terms 0 and 1 feed the sequencer; rise marks the first qualified cycle.
  assign rise    = qual[1:0] & ~qual_prev_q;
  assign y       = ~qual;
  assign seq_hit = (state_q == S_HIT);
  assign state   = state_q;

  // Term configuration and consecutive-match counters; a config write wins over counting.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < TERMS; i++) begin
        mask_q[i] <= '0;
        val_q[i]  <= '0;
        cnt_q[i]  <= '0;
      end
      qual_prev_q <= '0;
    end else begin
      qual_prev_q <= qual[1:0];
      for (int i = 0; i < TERMS; i++) begin
        if (cfg_we && (cfg_idx == 3'(i))) begin
          mask_q[i] <= cfg_mask;
          val_q[i]  <= cfg_val;
          cnt_q[i]  <= '0;
        end else if (in_valid) begin
          if (!match[i]) begin
            cnt_q[i] <= '0;
          end else if (cnt_q[i] != HOLD_C) begin
            cnt_q[i] <= cnt_q[i] + 4'd1;
          end
        end
      end
    end
  end

  // Sequencer state and window timer registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      timer_q <= '0;
    end else begin
      state_q <= state_d;
      timer_q <= timer_d;
    end
  end

  // Sequencer next state; term 1 only counts once term 0 has already armed us.
  always_comb begin
    state_d = state_q;
    timer_d = timer_q;
    case (state_q)
      S_IDLE: begin
        timer_d = '0;
        if (rise[0]) begin
          state_d = S_ARMED;
        end
      end
      S_ARMED: begin
        if (rise[1]) begin
          state_d = S_HIT;
          timer_d = '0;
        end else if (rise[0]) begin
          timer_d = '0;
        end else if (timer_q == WIN_LAST) begin
          state_d = S_IDLE;
          timer_d = '0;
        end else begin
          timer_d = timer_q + 8'd1;
        end
      end
      S_HIT: begin
        state_d = S_IDLE;
        timer_d = '0;
      end
      default: begin
        state_d = S_IDLE;
        timer_d = '0;
      end
    endcase
  end

  // Saturating hit counter; clear beats a simultaneous hit.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hit_count <= '0;
    end else if (clr) begin
      hit_count <= '0;
    end else if (seq_hit && (hit_count != 8'hFF)) begin
      hit_count <= hit_count + 8'd1;
    end
  end

endmodule

// File: tb/tb_g2_term_detector.sv
// Bench for g2_term_detector: a cycle model predicts the outputs after each
// edge, pushes them onto a queue, and each scenario task pops and compares.
module tb_g2_term_detector;

  localparam int HOLD = 3;
  localparam int WINDOW = 8;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [3:0] x = '0;
  logic       in_valid = 1'b0;
  logic       cfg_we = 1'b0;
  logic [2:0] cfg_idx = '0;
  logic [3:0] cfg_mask = '0;
  logic [3:0] cfg_val = '0;
  logic       clr = 1'b0;
  logic [1:0] y;
  logic       seq_hit;
  logic [1:0] state;
  logic [7:0] hit_count;

  g2_term_detector #(.WIDTH(4), .TERMS(2), .HOLD(HOLD), .WINDOW(WINDOW)) dut (
    .clk(clk), .rst_n(rst_n), .x(x), .in_valid(in_valid),
    .cfg_we(cfg_we), .cfg_idx(cfg_idx), .cfg_mask(cfg_mask), .cfg_val(cfg_val),
    .clr(clr), .y(y), .seq_hit(seq_hit), .state(state), .hit_count(hit_count)
  );

  always #5 clk = ~clk;

  // observed outputs packed as {y, seq_hit, state, hit_count}
  logic [12:0] obs;
  assign obs = {y, seq_hit, state, hit_count};

  logic [12:0] exp_q[$];
  logic [12:0] e;
  int n_checks = 0;
  int n_pass = 0;

  // reference model state
  logic [3:0] m_mask [2];
  logic [3:0] m_val  [2];
  logic [3:0] m_cnt  [2];
  logic [1:0] m_qprev;
  logic [1:0] m_state;
  logic [7:0] m_timer;
  logic [7:0] m_hc;

  logic [3:0] seq_x [8] = '{4'b0011, 4'b0011, 4'b0011, 4'b1111,
                            4'b1111, 4'b1111, 4'b1111, 4'b0000};

  task automatic model_reset();
    for (int i = 0; i < 2; i++) begin
      m_mask[i] = '0; m_val[i] = '0; m_cnt[i] = '0;
    end
    m_qprev = '0; m_state = 2'd0; m_timer = '0; m_hc = '0;
  endtask

  task automatic tick(input logic [3:0] tx, input logic tv, input logic twe,
                      input logic [2:0] tidx, input logic [3:0] tm,
                      input logic [3:0] tval, input logic tclr);
    logic [3:0] nc [2];
    logic [1:0] ql, rs, ns;
    logic [7:0] nt, nh;
    logic       mt;
    x = tx; in_valid = tv; cfg_we = twe; cfg_idx = tidx;
    cfg_mask = tm; cfg_val = tval; clr = tclr;
    for (int i = 0; i < 2; i++) begin
      mt = (m_mask[i] != 0) && ((tx & m_mask[i]) == (m_val[i] & m_mask[i]));
      ql[i] = (m_cnt[i] == HOLD);
      rs[i] = ql[i] && !m_qprev[i];
      if (twe && tidx == i) nc[i] = 0;
      else if (!tv) nc[i] = m_cnt[i];
      else if (!mt) nc[i] = 0;
      else if (m_cnt[i] == HOLD) nc[i] = 4'(HOLD);
      else nc[i] = m_cnt[i] + 1;
    end
    ns = m_state; nt = m_timer;
    case (m_state)
      2'd0: begin nt = 0; if (rs[0]) ns = 2'd1; end
      2'd1: begin
        if (rs[1]) begin ns = 2'd2; nt = 0; end
        else if (rs[0]) nt = 0;
        else if (m_timer == WINDOW - 1) begin ns = 2'd0; nt = 0; end
        else nt = m_timer + 1;
      end
      default: begin ns = 2'd0; nt = 0; end
    endcase
    if (tclr) nh = 0;
    else if (m_state == 2'd2 && m_hc != 8'hFF) nh = m_hc + 1;
    else nh = m_hc;
    for (int i = 0; i < 2; i++) begin
      if (twe && tidx == i) begin m_mask[i] = tm; m_val[i] = tval; end
      m_cnt[i] = nc[i];
    end
    m_qprev = ql; m_state = ns; m_timer = nt; m_hc = nh;
    exp_q.push_back({~(nc[1] == HOLD), ~(nc[0] == HOLD), ns == 2'd2, ns, nh});
    @(posedge clk);
    #1;
  endtask

  task automatic tk(input logic [3:0] tx, input logic tv);
    tick(tx, tv, 1'b0, 3'd0, 4'd0, 4'd0, 1'b0);
  endtask

  task automatic cfg(input logic [2:0] idx, input logic [3:0] m, input logic [3:0] v);
    tick(4'd0, 1'b0, 1'b1, idx, m, v, 1'b0);
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    model_reset();
    #12;
    n_checks++;
    if (obs !== 13'h1800) $display("FAIL reset_state observed=%h expected=%h", obs, 13'h1800);
    else n_pass++;
    rst_n = 1'b1;
  endtask

  task automatic test_qualify();
    logic [3:0] xs [4] = '{4'b0000, 4'b0011, 4'b0011, 4'b0011};
    logic       y0 [4] = '{1'b1, 1'b1, 1'b1, 1'b0};
    cfg(3'd0, 4'b0111, 4'b0011);
    e = exp_q.pop_front(); n_checks++;
    if (obs !== e) $display("FAIL qualify_cfg observed=%h expected=%h", obs, e); else n_pass++;
    for (int k = 0; k < 4; k++) begin
      tk(xs[k], 1'b1);
      e = exp_q.pop_front(); n_checks++;
      if (obs !== e) $display("FAIL qualify_step%0d observed=%h expected=%h", k, obs, e); else n_pass++;
      n_checks++;
      if (y !== {1'b1, y0[k]}) $display("FAIL qualify_y%0d observed=%b expected=%b", k, y, {1'b1, y0[k]});
      else n_pass++;
    end
  endtask

  task automatic test_break();
    logic [3:0] xs [7] = '{4'b0000, 4'b0011, 4'b0011, 4'b0111, 4'b0011, 4'b0011, 4'b0011};
    logic       y0 [7] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
    for (int k = 0; k < 7; k++) begin
      tk(xs[k], 1'b1);
      e = exp_q.pop_front(); n_checks++;
      if (obs !== e) $display("FAIL break_step%0d observed=%h expected=%h", k, obs, e); else n_pass++;
      n_checks++;
      if (y[0] !== y0[k]) $display("FAIL break_y0_%0d observed=%b expected=%b", k, y[0], y0[k]);
      else n_pass++;
    end
  endtask

  task automatic test_sequence();
    int hits = 0;
    bit saw_armed = 0;
    bit saw_hit = 0;
    cfg(3'd1, 4'b1100, 4'b1100);
    void'(exp_q.pop_front());
    for (int k = 0; k < 10; k++) begin
      tk(4'b0000, 1'b1);
      e = exp_q.pop_front(); n_checks++;
      if (obs !== e) $display("FAIL seq_flush%0d observed=%h expected=%h", k, obs, e); else n_pass++;
    end
    for (int k = 0; k < 8; k++) begin
      tk(seq_x[k], 1'b1);
      e = exp_q.pop_front(); n_checks++;
      if (obs !== e) $display("FAIL seq_step%0d observed=%h expected=%h", k, obs, e); else n_pass++;
      if (seq_hit) hits++;
      if (state == 2'd1) saw_armed = 1;
      if (state == 2'd2 && saw_armed) saw_hit = 1;
    end
    n_checks++;
    if (hits != 1 || !saw_hit || state !== 2'd0 || hit_count !== 8'd1)
      $display("FAIL seq_summary observed hits=%0d hit_state=%0d state=%0d count=%0d expected 1/1/0/1",
               hits, saw_hit, state, hit_count);
    else n_pass++;
  endtask

  task automatic test_window();
    int armed = 0;
    int hits = 0;
    for (int k = 0; k < 15; k++) begin
      tk(k < 3 ? 4'b0011 : 4'b0000, k < 3);
      e = exp_q.pop_front(); n_checks++;
      if (obs !== e) $display("FAIL window_step%0d observed=%h expected=%h", k, obs, e); else n_pass++;
      if (state == 2'd1) armed++;
      if (seq_hit) hits++;
    end
    n_checks++;
    if (armed != WINDOW || hits != 0 || state !== 2'd0 || hit_count !== 8'd1)
      $display("FAIL window_summary observed armed=%0d hits=%0d state=%0d count=%0d expected 8/0/0/1",
               armed, hits, state, hit_count);
    else n_pass++;
  endtask

  task automatic test_hold_cfg();
    tk(4'b0000, 1'b1); void'(exp_q.pop_front());
    tk(4'b0011, 1'b1); void'(exp_q.pop_front());
    tk(4'b0011, 1'b1); void'(exp_q.pop_front());
    for (int k = 0; k < 10; k++) begin
      tk(4'b0011, 1'b0);
      e = exp_q.pop_front(); n_checks++;
      if (obs !== e || y[0] !== 1'b1) $display("FAIL hold_idle%0d observed=%h expected=%h", k, obs, e);
      else n_pass++;
    end
    tk(4'b0011, 1'b1);
    e = exp_q.pop_front(); n_checks++;
    if (obs !== e || y[0] !== 1'b0) $display("FAIL hold_resume observed=%h expected=%h", obs, e);
    else n_pass++;
    tk(4'b0000, 1'b1); void'(exp_q.pop_front());
    tk(4'b0011, 1'b1); void'(exp_q.pop_front());
    tk(4'b0011, 1'b1); void'(exp_q.pop_front());
    tick(4'b0011, 1'b1, 1'b1, 3'd0, 4'b0111, 4'b0011, 1'b0);
    e = exp_q.pop_front(); n_checks++;
    if (obs !== e || y[0] !== 1'b1) $display("FAIL cfg_clears_cnt observed=%h expected=%h", obs, e);
    else n_pass++;
    for (int k = 0; k < 3; k++) begin
      tick(4'b0011, 1'b1, k == 2, 3'd5, 4'd0, 4'd0, 1'b0);
      e = exp_q.pop_front(); n_checks++;
      if (obs !== e || y[0] !== (k != 2))
        $display("FAIL cfg_recount%0d observed=%h expected=%h", k, obs, e);
      else n_pass++;
    end
  endtask

  task automatic test_reset_mid();
    for (int k = 0; k < 10; k++) begin
      tk(4'b0000, 1'b1); void'(exp_q.pop_front());
    end
    for (int s = 0; s < 4; s++) begin
      for (int k = 0; k < 8; k++) begin
        tk(seq_x[k], 1'b1);
        e = exp_q.pop_front(); n_checks++;
        if (obs !== e) $display("FAIL mid_seq%0d_%0d observed=%h expected=%h", s, k, obs, e); else n_pass++;
      end
    end
    for (int k = 0; k < 4; k++) begin
      tk(4'b0011, 1'b1); void'(exp_q.pop_front());
    end
    n_checks++;
    if (state !== 2'd1 || hit_count !== 8'd5)
      $display("FAIL mid_armed observed state=%0d count=%0d expected 1/5", state, hit_count);
    else n_pass++;
    #2 rst_n = 1'b0;
    model_reset();
    #1;
    n_checks++;
    if (obs !== 13'h1800) $display("FAIL mid_reset observed=%h expected=%h", obs, 13'h1800);
    else n_pass++;
    #3 rst_n = 1'b1;
  endtask

  task automatic test_back_to_back();
    cfg(3'd0, 4'b0111, 4'b0011); void'(exp_q.pop_front());
    cfg(3'd1, 4'b1100, 4'b1100); void'(exp_q.pop_front());
    for (int s = 0; s < 256; s++) begin
      for (int k = 0; k < 8; k++) begin
        tk(seq_x[k], 1'b1);
        e = exp_q.pop_front(); n_checks++;
        if (obs !== e) $display("FAIL b2b_seq%0d_%0d observed=%h expected=%h", s, k, obs, e); else n_pass++;
      end
    end
    n_checks++;
    if (hit_count !== 8'd255) $display("FAIL saturate observed=%0d expected=255", hit_count);
    else n_pass++;
    for (int k = 0; k < 8; k++) begin
      tick(seq_x[k], 1'b1, 1'b0, 3'd0, 4'd0, 4'd0, m_state == 2'd2);
      e = exp_q.pop_front(); n_checks++;
      if (obs !== e) $display("FAIL clr_step%0d observed=%h expected=%h", k, obs, e); else n_pass++;
    end
    n_checks++;
    if (hit_count !== 8'd0) $display("FAIL clr_priority observed=%0d expected=0", hit_count);
    else n_pass++;
  endtask

  initial begin
    test_reset();
    test_qualify();
    test_break();
    test_sequence();
    test_window();
    test_hold_cfg();
    test_reset_mid();
    test_back_to_back();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
